// File: rtl/input_sync_ctl.sv
// input_sync_ctl: conditions raw user inputs for the screen/state controller.
// - Synchronizes the mouse button and emits a one-cycle click pulse.
// - Debounces the board push-button and emits one pulse per accepted press.
// - Latches and clamps the pointer/paddle coordinates once per frame, at the
//   start of vertical blanking, so consumers never see mid-frame changes.
module input_sync_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned X_MAX           = 1023,
  parameter int unsigned Y_MAX           = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left_in,
  input  logic        button_in,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic [11:0] ypos_sec_in,
  input  logic        vblnk_in,
  output logic        mouse_left,
  output logic        mouse_left_lvl,
  output logic        button,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [11:0] ypos_sec
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter reaches DEBOUNCE_CYCLES on the edge where it currently holds
  // DEBOUNCE_CYCLES-1, so that edge is where the decision is taken.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]      X_MAX_C  = 12'(X_MAX);
  localparam logic [11:0]      Y_MAX_C  = 12'(Y_MAX);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } db_state_t;

  logic             ml_s1_q, ml_s2_q, ml_s3_q, ml_pulse_q;
  logic             bt_s1_q, bt_s2_q;
  logic             vblnk_d_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_pulse_q, btn_pulse_d;
  logic [11:0]      xpos_q, ypos_q, ypos_sec_q;

  // Mouse button synchronizer and rising-edge pulse (s3 holds the previous level).
  always_ff @(posedge clk) begin
    if (rst) begin
      ml_s1_q    <= 1'b0;
      ml_s2_q    <= 1'b0;
      ml_s3_q    <= 1'b0;
      ml_pulse_q <= 1'b0;
    end else begin
      ml_s1_q    <= mouse_left_in;
      ml_s2_q    <= ml_s1_q;
      ml_s3_q    <= ml_s2_q;
      ml_pulse_q <= ml_s2_q & ~ml_s3_q;
    end
  end

  // Push-button synchronizer feeding the debounce state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      bt_s1_q <= 1'b0;
      bt_s2_q <= 1'b0;
    end else begin
      bt_s1_q <= button_in;
      bt_s2_q <= bt_s1_q;
    end
  end

  // Debounce state, counter and press pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REL;
      cnt_q       <= '0;
      btn_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_pulse_q <= btn_pulse_d;
    end
  end

  // Debounce next-state logic: a level change is accepted only after it has
  // been stable for DEBOUNCE_CYCLES samples; only presses produce a pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btn_pulse_d = 1'b0;
    unique case (state_q)
      REL: begin
        if (bt_s2_q) begin
          state_d = CHK_P;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_P: begin
        if (!bt_s2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d     = PRS;
          cnt_d       = '0;
          btn_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRS: begin
        if (!bt_s2_q) begin
          state_d = CHK_R;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_R: begin
        if (bt_s2_q) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame-stable coordinates: sample and clamp only at the start of blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d_q  <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      ypos_sec_q <= '0;
    end else begin
      vblnk_d_q <= vblnk_in;
      if (vblnk_in && !vblnk_d_q) begin
        xpos_q     <= (xpos_in     > X_MAX_C) ? X_MAX_C : xpos_in;
        ypos_q     <= (ypos_in     > Y_MAX_C) ? Y_MAX_C : ypos_in;
        ypos_sec_q <= (ypos_sec_in > Y_MAX_C) ? Y_MAX_C : ypos_sec_in;
      end
    end
  end

  assign mouse_left     = ml_pulse_q;
  assign mouse_left_lvl = ml_s2_q;
  assign button         = btn_pulse_q;
  assign xpos           = xpos_q;
  assign ypos           = ypos_q;
  assign ypos_sec       = ypos_sec_q;

endmodule

// File: tb/tb_input_sync_ctl.sv
// Directed bench for input_sync_ctl with DEBOUNCE_CYCLES = 16.
// Tick index n means "sampled 1 ns after the n-th rising edge following the
// last stimulus change"; inputs changed after tick 0 are first seen at edge 1.
module tb_input_sync_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mouse_left_in, button_in, vblnk_in;
  logic [11:0] xpos_in, ypos_in, ypos_sec_in;
  logic        mouse_left, mouse_left_lvl, button;
  logic [11:0] xpos, ypos, ypos_sec;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [11:0] x_in;
    logic [11:0] y_in;
    logic [11:0] ys_in;
    logic [11:0] x_exp;
    logic [11:0] y_exp;
    logic [11:0] ys_exp;
  } vec_t;

  vec_t vecs[5];

  input_sync_ctl #(
    .DEBOUNCE_CYCLES(16),
    .X_MAX(1023),
    .Y_MAX(767)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mouse_left_in(mouse_left_in),
    .button_in(button_in),
    .xpos_in(xpos_in),
    .ypos_in(ypos_in),
    .ypos_sec_in(ypos_sec_in),
    .vblnk_in(vblnk_in),
    .mouse_left(mouse_left),
    .mouse_left_lvl(mouse_left_lvl),
    .button(button),
    .xpos(xpos),
    .ypos(ypos),
    .ypos_sec(ypos_sec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Run n ticks, recording the first tick index and count of each pulse.
  task automatic observe(input int n, output int fb, output int nb,
                         output int fm, output int nm);
    fb = -1; nb = 0; fm = -1; nm = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (button) begin
        nb++;
        if (fb < 0) fb = i;
      end
      if (mouse_left) begin
        nm++;
        if (fm < 0) fm = i;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fb, nb, fm, nm, bad;

    vecs[0] = '{12'd100,  12'd200,  12'd300,  12'd100,  12'd200, 12'd300};
    vecs[1] = '{12'd1500, 12'd4095, 12'd767,  12'd1023, 12'd767, 12'd767};
    vecs[2] = '{12'd1023, 12'd768,  12'd0,    12'd1023, 12'd767, 12'd0};
    vecs[3] = '{12'd1024, 12'd767,  12'd766,  12'd1023, 12'd767, 12'd766};
    vecs[4] = '{12'd0,    12'd0,    12'd4095, 12'd0,    12'd0,   12'd767};

    // Reset with every input high.
    rst = 1'b1; mouse_left_in = 1'b1; button_in = 1'b1; vblnk_in = 1'b1;
    xpos_in = 12'd500; ypos_in = 12'hFFF; ypos_sec_in = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_outputs", longint'({mouse_left, mouse_left_lvl, button, xpos, ypos, ypos_sec}), 0);
    end
    rst = 1'b0;
    fb = -1; nb = 0; fm = -1; nm = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (button) begin nb++; if (fb < 0) fb = i; end
      if (mouse_left) begin nm++; if (fm < 0) fm = i; end
      if (i == 1) begin
        chk("rst_xpos_latch", xpos, 500);
        chk("rst_ypos_clamp", ypos, 767);
        chk("rst_lvl_before", mouse_left_lvl, 0);
      end
      if (i == 2) chk("rst_lvl_after", mouse_left_lvl, 1);
    end
    chk("rst_button_first", fb, 18);
    chk("rst_button_count", nb, 1);
    chk("rst_click_first", fm, 3);
    chk("rst_click_count", nm, 1);

    mouse_left_in = 1'b0; button_in = 1'b0; vblnk_in = 1'b0;
    repeat (40) tick();

    // Two long clicks: one pulse each, level delayed by two edges.
    for (int b = 0; b < 2; b++) begin
      mouse_left_in = 1'b1;
      fm = -1; nm = 0;
      for (int i = 1; i <= 200; i++) begin
        tick();
        if (mouse_left) begin nm++; if (fm < 0) fm = i; end
        if (i == 1) chk("click_lvl_lag", mouse_left_lvl, 0);
        if (i == 2) chk("click_lvl_high", mouse_left_lvl, 1);
      end
      chk("click_pulse_at", fm, 3);
      chk("click_pulse_count", nm, 1);
      mouse_left_in = 1'b0;
      nm = 0;
      for (int i = 1; i <= 200; i++) begin
        tick();
        if (mouse_left) nm++;
        if (i == 1) chk("click_lvl_fall_lag", mouse_left_lvl, 1);
        if (i == 2) chk("click_lvl_low", mouse_left_lvl, 0);
      end
      chk("click_no_pulse_low", nm, 0);
    end

    // Press bounce: toggle every 5 cycles, then hold high.
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) button_in = ~button_in;
      tick();
      if (button) nb++;
    end
    chk("bounce_no_pulse", nb, 0);
    button_in = 1'b1;
    observe(40, fb, nb, fm, nm);
    chk("bounce_pulse_at", fb, 18);
    chk("bounce_pulse_count", nb, 1);

    // Release bounce for 10 cycles: no pulse, and the release still settles.
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      button_in = ((i / 2) % 2) == 1;
      tick();
      if (button) nb++;
    end
    button_in = 1'b0;
    observe(40, fb, bad, fm, nm);
    chk("release_no_pulse", nb + bad, 0);
    button_in = 1'b1;
    observe(40, fb, nb, fm, nm);
    chk("repress_pulse_at", fb, 18);
    button_in = 1'b0;
    repeat (40) tick();

    // Frame latch: mid-frame change is invisible until blanking starts.
    xpos_in = 12'd100; ypos_in = 12'd10; ypos_sec_in = 12'd20;
    tick();
    vblnk_in = 1'b1;
    tick();
    chk("frame_initial_x", xpos, 100);
    vblnk_in = 1'b0;
    repeat (10) tick();
    xpos_in = 12'd300;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (xpos !== 12'd100) bad++;
    end
    chk("frame_hold_midframe", bad, 0);
    vblnk_in = 1'b1;
    tick();
    chk("frame_update", xpos, 300);
    xpos_in = 12'd400;
    repeat (5) tick();
    chk("frame_no_retrigger", xpos, 300);
    vblnk_in = 1'b0;
    tick();

    // Clamp table applied at successive blanking starts.
    for (int v = 0; v < 5; v++) begin
      xpos_in = vecs[v].x_in; ypos_in = vecs[v].y_in; ypos_sec_in = vecs[v].ys_in;
      vblnk_in = 1'b0;
      repeat (2) tick();
      vblnk_in = 1'b1;
      tick();
      chk("clamp_x", xpos, vecs[v].x_exp);
      chk("clamp_y", ypos, vecs[v].y_exp);
      chk("clamp_ysec", ypos_sec, vecs[v].ys_exp);
    end
    vblnk_in = 1'b0;
    repeat (3) tick();

    // Click pulse and position update on the same edge.
    xpos_in = 12'd777;
    mouse_left_in = 1'b1;
    repeat (2) tick();
    vblnk_in = 1'b1;
    tick();
    chk("simul_click", mouse_left, 1);
    chk("simul_xpos", xpos, 777);
    tick();
    chk("simul_click_end", mouse_left, 0);
    mouse_left_in = 1'b0; vblnk_in = 1'b0;
    repeat (5) tick();

    // Reset when the debounce counter is at 10.
    button_in = 1'b1;
    observe(12, fb, nb, fm, nm);
    chk("middb_no_early", nb, 0);
    rst = 1'b1;
    tick();
    chk("middb_rst_outs", longint'({button, mouse_left_lvl, xpos}), 0);
    rst = 1'b0;
    observe(40, fb, nb, fm, nm);
    chk("middb_pulse_at", fb, 18);
    chk("middb_pulse_count", nb, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
